reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Post-PLL reset controller that sequences release of per-domain synchronous resets once the PLL reports stable lock. It sits directly downstream of the clock generator and replaces its simple lock-gated reset counter. It adds the following:
- staged per-domain reset release;
- lock-loss recovery;
- software-requested re-reset;
- a sticky lock-loss flag for status readback.

## Interface
Parameters:
- NUM_DOMAINS, 2: number of reset outputs; domain 0 is released first.
- STABLE_CYCLES, 32: consecutive synchronized-lock cycles required before release; must be ≥2.
- STAGE_CYCLES, 16: cycles between successive domain releases; must be ≥1.
- HOLD_CYCLES, 8: cycles all resets are held after a soft reset request; must be ≥1.

Ports:
- clk  in  1  single clock (the buffered USB-rate clock); every flop in the block is on its rising edge.
- reset  in  1  synchronous, active-high block reset.
- pll_locked  in  1  raw PLL lock; asynchronous to clk.
- soft_reset_req  in  1  single-cycle pulse requesting re-reset of all domains.
- lock_lost_clear  in  1  single-cycle pulse that clears lock_lost.
- domain_reset  out  NUM_DOMAINS  active-high synchronous resets, one per domain.
- all_ready  out  1  high only in RUN.
- lock_lost  out  1  sticky flag: lock dropped after release had begun.
- seq_state  out  3  current FSM state encoding, for debug.

## Operation
- pll_locked passes through a 2-flop synchronizer to give locked_s. All decisions use locked_s.
- Reset values (during reset and on the edge after it):
  - domain_reset = all ones, all_ready = 0, lock_lost = 0;
  - synchronizer flops = 0, counters = 0, state = WAIT_LOCK.
- WAIT_LOCK: all domain resets asserted. If locked_s = 1, go to STABILIZE with cnt = 0.
- STABILIZE:
  - If locked_s = 0, return to WAIT_LOCK. This does not set lock_lost.
  - Else if cnt = STABLE_CYCLES−1, go to RELEASE.
  - Otherwise cnt++.
- RELEASE:
  - On entry, domain_reset[0] deasserts, and idx = 0, cnt = 0.
  - Each cycle cnt++. When cnt = STAGE_CYCLES−1, cnt wraps to 0.
  - At the wrap: if idx = NUM_DOMAINS−1, go to RUN; otherwise idx++ and deassert domain_reset[idx+1].
  - A released domain stays released; domain resets never re-assert individually.
- RUN: all_ready = 1 and all domain_reset = 0. soft_reset_req = 1 → HOLD.
- HOLD:
  - On entry, all domain_reset = 1 and all_ready = 0.
  - After HOLD_CYCLES cycles in HOLD, go to RELEASE. STABILIZE is skipped because lock is already proven.
- Lock loss: locked_s = 0 while in RELEASE, RUN or HOLD. On the next edge:
  - all domain_reset = 1, all_ready = 0, lock_lost = 1;
  - state = WAIT_LOCK; counters are cleared.
- Priorities:
  - Lock loss beats soft_reset_req.
  - soft_reset_req is ignored outside RUN, including while in HOLD.
  - If lock_lost is set and cleared on the same edge, set wins.
  - lock_lost_clear has no other effect.
- Reset asserted mid-sequence: return to reset values on the next edge, regardless of state.
- Counter widths: $clog2 of the largest count parameter, computed separately per counter. Counters never overflow because each wraps at its terminal count.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- pll_locked rising to locked_s high: 2 edges.
- Release latency, with edge 0 = first edge sampling pll_locked = 1 and defaults used:
  - STABILIZE entered at edge 2;
  - domain_reset[0] low after edge 2+STABLE_CYCLES (edge 34);
  - domain_reset[k] low STAGE_CYCLES edges later than domain_reset[k−1] (domain 1 after edge 50);
  - all_ready high after edge 2+STABLE_CYCLES+NUM_DOMAINS·STAGE_CYCLES (edge 66).
- Lock-loss response: all resets re-assert 3 edges after pll_locked falls (2 synchronizer edges + 1 FSM edge).
- Soft reset, pulse sampled in RUN at edge s:
  - resets asserted after s;
  - RELEASE entered after s+HOLD_CYCLES;
  - all_ready after s+HOLD_CYCLES+NUM_DOMAINS·STAGE_CYCLES.

## Structure
- Package reset_seq_pkg holds:
  - the state enum: WAIT_LOCK = 0, STABILIZE = 1, RELEASE = 2, RUN = 3, HOLD = 4;
  - width helper functions.
- Sub-module sync_2ff: a generic 2-flop synchronizer with parameterized reset value, instantiated for pll_locked.
- Top level contains the FSM, the shared cnt and idx counters, and the lock_lost flag.

## Test plan
Defaults apply unless a scenario states otherwise.
- Power-up: reset for 4 cycles, then pll_locked = 1 held → domain_reset = 2'b11 until edge 34, 2'b10 until edge 50, 2'b00 after, all_ready = 1 after edge 66, lock_lost = 0.
- Lock glitch in STABILIZE: pll_locked low for 3 cycles at edge 20 → FSM returns to WAIT_LOCK, count restarts from the next lock, lock_lost stays 0, release is delayed accordingly.
- Lock loss in RUN: drop pll_locked → domain_reset = 2'b11 and all_ready = 0 3 edges later, lock_lost = 1; re-lock repeats the full power-up timing; a lock_lost_clear pulse → lock_lost = 0.
- Soft reset: pulse soft_reset_req in RUN → resets asserted next edge, domain_reset[0] low 8 edges later, all_ready 40 edges after the pulse; a second pulse during HOLD is ignored.
- Simultaneous events: soft_reset_req and lock loss on the same edge → WAIT_LOCK and lock_lost = 1; lock_lost_clear on the edge a loss is detected → lock_lost = 1.
- Parameter sweep: NUM_DOMAINS = 4, STAGE_CYCLES = 1 → domains release on 4 consecutive edges in order 0..3, and all_ready rises on the edge after domain 3 releases.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the post-PLL reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold count values 0..n-1, never less than one.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals asynchronous to clk; output lags input by 2 edges.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Post-PLL reset controller: waits for stable lock, then releases domain resets one stage
// at a time; re-asserts everything on lock loss or a software re-reset request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS   = 2,
  parameter int STABLE_CYCLES = 32,
  parameter int STAGE_CYCLES  = 16,
  parameter int HOLD_CYCLES   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   soft_reset_req,
  input  logic                   lock_lost_clear,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_ready,
  output logic                   lock_lost,
  output logic [2:0]             seq_state
);

  localparam int CNT_W = width_for(max3(STABLE_CYCLES, STAGE_CYCLES, HOLD_CYCLES));
  localparam int IDX_W = width_for(NUM_DOMAINS);

  localparam logic [CNT_W-1:0]       STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       STAGE_LAST  = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]       IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] FIRST_REL   = ~(NUM_DOMAINS'(1));

  logic                   w_locked_s;
  logic [IDX_W-1:0]       w_next_idx;
  seq_state_t             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_DOMAINS-1:0] r_domain_reset;
  logic                   r_all_ready;
  logic                   r_lock_lost;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b0)
  ) u_lock_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (pll_locked),
    .o_q  (w_locked_s)
  );

  assign w_next_idx = r_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= WAIT_LOCK;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_domain_reset <= '1;
      r_all_ready    <= 1'b0;
      r_lock_lost    <= 1'b0;
    end else begin
      // A loss detected on this edge overrides the clear assigned here.
      if (lock_lost_clear) r_lock_lost <= 1'b0;

      case (r_state)
        WAIT_LOCK: begin
          r_domain_reset <= '1;
          r_all_ready    <= 1'b0;
          r_cnt          <= '0;
          r_idx          <= '0;
          if (w_locked_s) r_state <= STABILIZE;
        end
        STABILIZE: begin
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_LAST) begin
            r_state        <= RELEASE;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_domain_reset <= FIRST_REL;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RELEASE, RUN, HOLD: begin
          if (!w_locked_s) begin
            r_state        <= WAIT_LOCK;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_domain_reset <= '1;
            r_all_ready    <= 1'b0;
            r_lock_lost    <= 1'b1;
          end else if (r_state == RELEASE) begin
            if (r_cnt == STAGE_LAST) begin
              r_cnt <= '0;
              if (r_idx == IDX_LAST) begin
                r_state     <= RUN;
                r_all_ready <= 1'b1;
              end else begin
                r_idx          <= w_next_idx;
                r_domain_reset <= r_domain_reset & ~(NUM_DOMAINS'(1) << w_next_idx);
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (r_state == RUN) begin
            r_domain_reset <= '0;
            r_all_ready    <= 1'b1;
            if (soft_reset_req) begin
              r_state        <= HOLD;
              r_cnt          <= '0;
              r_domain_reset <= '1;
              r_all_ready    <= 1'b0;
            end
          end else begin
            // Lock is already proven, so HOLD goes straight back to staged release.
            if (r_cnt == HOLD_LAST) begin
              r_state        <= RELEASE;
              r_cnt          <= '0;
              r_idx          <= '0;
              r_domain_reset <= FIRST_REL;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state        <= WAIT_LOCK;
          r_cnt          <= '0;
          r_idx          <= '0;
          r_domain_reset <= '1;
          r_all_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign domain_reset = r_domain_reset;
  assign all_ready    = r_all_ready;
  assign lock_lost    = r_lock_lost;
  assign seq_state    = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: default instance plus a 4-domain, 1-cycle-stage instance on shared inputs.
module tb_reset_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       lock_lost_clear;
  logic [1:0] domain_reset;
  logic       all_ready;
  logic       lock_lost;
  logic [2:0] seq_state;
  logic [3:0] domain_reset4;
  logic       all_ready4;
  logic       lock_lost4;
  logic [2:0] seq_state4;

  int total = 0;
  int bad   = 0;

  reset_sequencer u_dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .lock_lost_clear(lock_lost_clear),
    .domain_reset   (domain_reset),
    .all_ready      (all_ready),
    .lock_lost      (lock_lost),
    .seq_state      (seq_state)
  );

  reset_sequencer #(
    .NUM_DOMAINS (4),
    .STAGE_CYCLES(1)
  ) u_dut4 (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .soft_reset_req (soft_reset_req),
    .lock_lost_clear(lock_lost_clear),
    .domain_reset   (domain_reset4),
    .all_ready      (all_ready4),
    .lock_lost      (lock_lost4),
    .seq_state      (seq_state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after each.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    pll_locked      = 1'b0;
    soft_reset_req  = 1'b0;
    lock_lost_clear = 1'b0;
    step(4);
    chk("rst_dom",   32'(domain_reset), 32'h3);
    chk("rst_ready", 32'(all_ready),    32'h0);
    chk("rst_lost",  32'(lock_lost),    32'h0);
    chk("rst_state", 32'(seq_state),    32'h0);
    chk("rst_dom4",  32'(domain_reset4), 32'hF);

    // Power-up: edge 0 is the next edge.
    reset      = 1'b0;
    pll_locked = 1'b1;
    step(2);
    chk("pu_e1_state", 32'(seq_state), 32'h0);
    step(1);
    chk("pu_e2_state", 32'(seq_state), 32'h1);
    step(31);
    chk("pu_e33_dom",  32'(domain_reset),  32'h3);
    chk("pu_e33_dom4", 32'(domain_reset4), 32'hF);
    step(1);
    chk("pu_e34_dom",   32'(domain_reset),  32'h2);
    chk("pu_e34_state", 32'(seq_state),     32'h2);
    chk("pu_e34_dom4",  32'(domain_reset4), 32'hE);
    step(1);
    chk("pu_e35_dom4", 32'(domain_reset4), 32'hC);
    step(1);
    chk("pu_e36_dom4", 32'(domain_reset4), 32'h8);
    step(1);
    chk("pu_e37_dom4", 32'(domain_reset4), 32'h0);
    chk("pu_e37_rdy4", 32'(all_ready4),    32'h0);
    step(1);
    chk("pu_e38_rdy4", 32'(all_ready4), 32'h1);
    chk("pu_e38_st4",  32'(seq_state4), 32'h3);
    step(11);
    chk("pu_e49_dom", 32'(domain_reset), 32'h2);
    step(1);
    chk("pu_e50_dom", 32'(domain_reset), 32'h0);
    chk("pu_e50_rdy", 32'(all_ready),    32'h0);
    step(15);
    chk("pu_e65_rdy", 32'(all_ready), 32'h0);
    step(1);
    chk("pu_e66_rdy",   32'(all_ready), 32'h1);
    chk("pu_e66_state", 32'(seq_state), 32'h3);
    chk("pu_e66_lost",  32'(lock_lost), 32'h0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    step(2);
    chk("ll_f1_dom", 32'(domain_reset), 32'h0);
    chk("ll_f1_rdy", 32'(all_ready),    32'h1);
    step(1);
    chk("ll_f2_dom",   32'(domain_reset), 32'h3);
    chk("ll_f2_rdy",   32'(all_ready),    32'h0);
    chk("ll_f2_lost",  32'(lock_lost),    32'h1);
    chk("ll_f2_state", 32'(seq_state),    32'h0);

    // Re-lock repeats power-up timing.
    pll_locked = 1'b1;
    step(34);
    chk("rl_e33_dom",  32'(domain_reset), 32'h3);
    chk("rl_e33_lost", 32'(lock_lost),    32'h1);
    step(1);
    chk("rl_e34_dom", 32'(domain_reset), 32'h2);
    step(16);
    chk("rl_e50_dom", 32'(domain_reset), 32'h0);
    step(16);
    chk("rl_e66_rdy", 32'(all_ready), 32'h1);
    lock_lost_clear = 1'b1;
    step(1);
    lock_lost_clear = 1'b0;
    chk("clr_lost", 32'(lock_lost), 32'h0);
    chk("clr_rdy",  32'(all_ready), 32'h1);

    // Soft reset, with a second pulse during HOLD that must be ignored.
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    chk("sr_s_dom",   32'(domain_reset), 32'h3);
    chk("sr_s_rdy",   32'(all_ready),    32'h0);
    chk("sr_s_state", 32'(seq_state),    32'h4);
    step(3);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    step(3);
    chk("sr_s7_state", 32'(seq_state),    32'h4);
    chk("sr_s7_dom",   32'(domain_reset), 32'h3);
    step(1);
    chk("sr_s8_dom",   32'(domain_reset), 32'h2);
    chk("sr_s8_state", 32'(seq_state),    32'h2);
    step(31);
    chk("sr_s39_rdy", 32'(all_ready), 32'h0);
    step(1);
    chk("sr_s40_rdy", 32'(all_ready), 32'h1);

    // Soft reset request and lock loss detected on the same edge.
    pll_locked = 1'b0;
    step(2);
    chk("sim_pre_lost", 32'(lock_lost), 32'h0);
    soft_reset_req = 1'b1;
    step(1);
    soft_reset_req = 1'b0;
    chk("sim_state", 32'(seq_state),    32'h0);
    chk("sim_lost",  32'(lock_lost),    32'h1);
    chk("sim_dom",   32'(domain_reset), 32'h3);

    // Block reset clears the sticky flag along with everything else.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_rst_lost",  32'(lock_lost),    32'h0);
    chk("mid_rst_state", 32'(seq_state),    32'h0);
    chk("mid_rst_dom",   32'(domain_reset), 32'h3);

    // Lock glitch during STABILIZE: low for edges 20..22, re-lock sampled at 23.
    pll_locked = 1'b1;
    step(20);
    pll_locked = 1'b0;
    step(2);
    chk("gl_e21_state", 32'(seq_state), 32'h1);
    step(1);
    pll_locked = 1'b1;
    chk("gl_e22_state", 32'(seq_state), 32'h0);
    chk("gl_e22_lost",  32'(lock_lost), 32'h0);
    step(2);
    chk("gl_e24_state", 32'(seq_state), 32'h0);
    step(1);
    chk("gl_e25_state", 32'(seq_state), 32'h1);
    step(31);
    chk("gl_e56_dom", 32'(domain_reset), 32'h3);
    step(1);
    chk("gl_e57_dom",  32'(domain_reset), 32'h2);
    chk("gl_e57_lost", 32'(lock_lost),    32'h0);

    // Lock lost during RELEASE with a clear pulse on the detecting edge.
    pll_locked = 1'b0;
    step(2);
    lock_lost_clear = 1'b1;
    step(1);
    lock_lost_clear = 1'b0;
    chk("lc_lost",  32'(lock_lost),    32'h1);
    chk("lc_state", 32'(seq_state),    32'h0);
    chk("lc_dom",   32'(domain_reset), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
